time_set_ctrl: RTL and testbench

User-facing time-setting controller that drives the load/data side of the hour and minute counters and reads their databus outputs. It captures the running time into shadow registers when set mode is entered, lets the user step the hour and then the minute field up or down with wrap-around, and commits both fields in a single synchronous load cycle. It sits between the debounced button front end and the hour/minute counters.

---
 rtl/clock_pkg.sv | 31 +++
 rtl/time_set_ctrl_if.sv | 27 ++
 rtl/time_set_ctrl_wrap_step.sv | 26 ++
 rtl/time_set_ctrl.sv | 154 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting path: controller states,
// display field codes and the default hour/minute limits used by the counters.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_EDIT_HOUR = 3'd2,
    ST_EDIT_MIN  = 3'd3,
    ST_COMMIT    = 3'd4
  } set_state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  localparam int HOUR_W       = 5;
  localparam int MIN_W        = 6;
  localparam int DEF_HOUR_MAX = 23;
  localparam int DEF_MIN_MAX  = 59;

  // Display field code for a given controller state.
  function automatic logic [1:0] field_of(input set_state_t s);
    case (s)
      ST_EDIT_HOUR: return FIELD_HOUR;
      ST_EDIT_MIN:  return FIELD_MIN;
      default:      return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Counter-side bus of the time-setting controller: databus reads from the
// hour/minute counters and the load strobes/values going back to them.
interface time_set_ctrl_if;
  import clock_pkg::*;

  logic [HOUR_W-1:0] hour_bus;
  logic [MIN_W-1:0]  min_bus;
  logic              hour_en;
  logic              min_en;
  logic              hour_load;
  logic              min_load;
  logic [HOUR_W-1:0] hour_data;
  logic [MIN_W-1:0]  min_data;

  // Controller side.
  modport master (
    input  hour_bus, min_bus,
    output hour_en, min_en, hour_load, min_load, hour_data, min_data
  );

  // Counter side.
  modport slave (
    output hour_bus, min_bus,
    input  hour_en, min_en, hour_load, min_load, hour_data, min_data
  );

endinterface

// File: rtl/time_set_ctrl_wrap_step.sv
// One up/down step of a 0..MAX field with wrap-around. Purely combinational.
// inc and dec together leave the value unchanged; a value above MAX is
// treated as the top of the range when stepping.
module wrap_step #(
  parameter int W   = 5,
  parameter int MAX = 23
) (
  input  logic [W-1:0] val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] nxt_o
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  // Next value of the field after at most one step.
  always_comb begin
    nxt_o = val_i;
    if (inc_i && !dec_i) begin
      nxt_o = (val_i >= MAXV) ? '0 : val_i + W'(1);
    end else if (dec_i && !inc_i) begin
      nxt_o = ((val_i == '0) || (val_i > MAXV)) ? MAXV : val_i - W'(1);
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: snapshots the running hour/minute counters into
// shadow registers, lets the user step hour then minute, and writes both back
// in one load cycle. An idle edit times out back to IDLE without loading.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int HOUR_MAX  = DEF_HOUR_MAX,
  parameter int MIN_MAX   = DEF_MIN_MAX,
  parameter int BLINK_DIV = 25_000_000,
  parameter int TIMEOUT   = 500_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_mode,
  input  logic                   btn_inc,
  input  logic                   btn_dec,
  time_set_ctrl_if.master        cnt_if,
  output logic [1:0]             field,
  output logic                   blink
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  // Captured values above the field range are replaced by 0.
  function automatic logic [HOUR_W-1:0] clamp_hour(input logic [HOUR_W-1:0] v);
    return (v > HOUR_W'(HOUR_MAX)) ? '0 : v;
  endfunction

  function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] v);
    return (v > MIN_W'(MIN_MAX)) ? '0 : v;
  endfunction

  set_state_t        state_q, state_d;
  logic [HOUR_W-1:0] hour_sh_q, hour_sh_d;
  logic [MIN_W-1:0]  min_sh_q, min_sh_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [BW-1:0]     blk_cnt_q, blk_cnt_d;
  logic              blink_q, blink_d;

  logic [HOUR_W-1:0] hour_step;
  logic [MIN_W-1:0]  min_step;
  logic              step_btn;
  logic              edit_d;

  assign step_btn = btn_inc | btn_dec;
  assign edit_d   = (state_d == ST_EDIT_HOUR) || (state_d == ST_EDIT_MIN);

  wrap_step #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour_step (
    .val_i (hour_sh_q),
    .inc_i (btn_inc),
    .dec_i (btn_dec),
    .nxt_o (hour_step)
  );

  wrap_step #(.W(MIN_W), .MAX(MIN_MAX)) u_min_step (
    .val_i (min_sh_q),
    .inc_i (btn_inc),
    .dec_i (btn_dec),
    .nxt_o (min_step)
  );

  // State, shadow and timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hour_sh_q <= '0;
      min_sh_q  <= '0;
      tmo_q     <= '0;
      blk_cnt_q <= '0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hour_sh_q <= hour_sh_d;
      min_sh_q  <= min_sh_d;
      tmo_q     <= tmo_d;
      blk_cnt_q <= blk_cnt_d;
      blink_q   <= blink_d;
    end
  end

  // Next state, shadow updates, timeout counting and counter-bus outputs.
  // Mode beats a step in the same cycle; any button restarts the timeout.
  always_comb begin
    state_d          = state_q;
    hour_sh_d        = hour_sh_q;
    min_sh_d         = min_sh_q;
    tmo_d            = '0;
    cnt_if.hour_en   = 1'b0;
    cnt_if.min_en    = 1'b0;
    cnt_if.hour_load = 1'b0;
    cnt_if.min_load  = 1'b0;
    cnt_if.hour_data = '0;
    cnt_if.min_data  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (btn_mode) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cnt_if.hour_en = 1'b1;
        cnt_if.min_en  = 1'b1;
        hour_sh_d      = clamp_hour(cnt_if.hour_bus);
        min_sh_d       = clamp_min(cnt_if.min_bus);
        state_d        = ST_EDIT_HOUR;
      end
      ST_EDIT_HOUR: begin
        if (btn_mode)             state_d   = ST_EDIT_MIN;
        else if (step_btn)        hour_sh_d = hour_step;
        else if (tmo_q == TMO_LAST) state_d = ST_IDLE;
        else                      tmo_d     = tmo_q + TW'(1);
      end
      ST_EDIT_MIN: begin
        if (btn_mode)             state_d  = ST_COMMIT;
        else if (step_btn)        min_sh_d = min_step;
        else if (tmo_q == TMO_LAST) state_d = ST_IDLE;
        else                      tmo_d    = tmo_q + TW'(1);
      end
      ST_COMMIT: begin
        cnt_if.hour_load = 1'b1;
        cnt_if.min_load  = 1'b1;
        cnt_if.hour_data = hour_sh_q;
        cnt_if.min_data  = min_sh_q;
        state_d          = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Blink phase: forced on when an edit state is entered or a step is
  // pressed, otherwise toggled every BLINK_DIV cycles; off outside editing.
  always_comb begin
    blink_d   = 1'b0;
    blk_cnt_d = '0;
    if (edit_d) begin
      if ((state_d != state_q) || step_btn) begin
        blink_d = 1'b1;
      end else if (blk_cnt_q == BLK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_d   = blink_q;
        blk_cnt_d = blk_cnt_q + BW'(1);
      end
    end
  end

  assign field = field_of(state_q);
  assign blink = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed button sequences against a simple
// hour/minute counter model; load transactions are checked by a scoreboard.
module tb_time_set_ctrl;
  import clock_pkg::*;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [1:0] field;
  logic       blink;

  logic [4:0] hour_cnt, hour_pre;
  logic [5:0] min_cnt, min_pre;
  logic       preset = 1'b0;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_loads = 0;

  time_set_ctrl_if cif();

  assign cif.hour_bus = hour_cnt;
  assign cif.min_bus  = min_cnt;

  time_set_ctrl #(
    .HOUR_MAX (23),
    .MIN_MAX  (59),
    .BLINK_DIV(4),
    .TIMEOUT  (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .cnt_if  (cif),
    .field   (field),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  // Hour/minute counter model: presettable by the bench, loaded by strobes.
  always @(posedge clk) begin
    if (preset) begin
      hour_cnt <= hour_pre;
      min_cnt  <= min_pre;
    end else begin
      if (cif.hour_load) hour_cnt <= cif.hour_data;
      if (cif.min_load)  min_cnt  <= cif.min_data;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // Scoreboard monitor: every load cycle must match the next expected load.
  always @(negedge clk) begin
    if (rst_n && (cif.hour_load || cif.min_load)) begin
      n_loads++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_load: hour_data %0d min_data %0d, expected no load",
                 cif.hour_data, cif.min_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("load_hour_data", 32'(cif.hour_data), 32'(mon_e.h));
        chk("load_min_data",  32'(cif.min_data),  32'(mon_e.m));
        chk("load_pair",      32'({cif.hour_load, cif.min_load}), 32'd3);
        chk("load_no_en",     32'({cif.hour_en, cif.min_en}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    tick();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
  endtask

  task automatic set_counters(input logic [4:0] h, input logic [5:0] m);
    hour_pre = h;
    min_pre  = m;
    preset   = 1'b1;
    tick();
    preset   = 1'b0;
  endtask

  // IDLE -> CAPTURE -> EDIT_HOUR; returns one ns into the first edit cycle.
  task automatic enter_edit();
    press(1'b1, 1'b0, 1'b0);
    tick();
  endtask

  // From EDIT_MIN: expect one load of (h, m) and the counters to hold it.
  task automatic commit_expect(input string tag, input logic [4:0] h, input logic [5:0] m);
    exp_q.push_back('{h: h, m: m});
    press(1'b1, 1'b0, 1'b0);
    chk({tag, "_commit_load"}, 32'({cif.hour_load, cif.min_load}), 32'd3);
    tick();
    chk({tag, "_after_load"}, 32'({cif.hour_load, cif.min_load, field}), 32'd0);
    chk({tag, "_counter"}, 32'({hour_cnt, min_cnt}), 32'({h, m}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    set_counters(5'd0, 6'd0);
    tick();
    chk("reset_field", 32'(field), 32'd0);
    chk("reset_blink", 32'(blink), 32'd0);
    chk("reset_strobes", 32'({cif.hour_en, cif.min_en, cif.hour_load, cif.min_load}), 32'd0);
    chk("reset_data", 32'({cif.hour_data, cif.min_data}), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // IDLE ignores steps
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    chk("idle_ignores_steps", 32'({field, cif.hour_en, cif.min_en}), 32'd0);

    // Capture 14:37, hour +1, minute -2 -> 15:35
    set_counters(5'd14, 6'd37);
    press(1'b1, 1'b0, 1'b0);
    chk("capture_en", 32'({cif.hour_en, cif.min_en}), 32'd3);
    chk("capture_field", 32'(field), 32'd0);
    chk("capture_data_gated", 32'({cif.hour_data, cif.min_data, cif.hour_load}), 32'd0);
    tick();
    chk("capture_en_one_cycle", 32'({cif.hour_en, cif.min_en}), 32'd0);
    chk("edit_hour_field", 32'(field), 32'(FIELD_HOUR));
    chk("edit_hour_blink_entry", 32'(blink), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("edit_min_field", 32'(field), 32'(FIELD_MIN));
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    chk("edit_data_gated", 32'({cif.hour_data, cif.min_data}), 32'd0);
    commit_expect("basic", 5'd15, 6'd35);

    // Wrap upward from 23:59, with blink cadence on the way
    set_counters(5'd23, 6'd59);
    enter_edit();
    chk("blink_e0", 32'(blink), 32'd1);
    tick(); tick(); tick();
    chk("blink_e3", 32'(blink), 32'd1);
    tick();
    chk("blink_e4_toggle", 32'(blink), 32'd0);
    press(0, 1, 0);
    chk("blink_after_press", 32'(blink), 32'd1);
    press(1, 0, 0);
    press(0, 1, 0);
    commit_expect("wrap_up", 5'd0, 6'd0);

    // Wrap downward from 00:00
    enter_edit();
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 0, 1);
    commit_expect("wrap_down", 5'd23, 6'd59);

    // Simultaneous inputs: inc+dec no change, mode+inc drops the step
    set_counters(5'd10, 6'd20);
    enter_edit();
    press(0, 1, 1);
    press(1, 1, 0);
    chk("mode_inc_field", 32'(field), 32'(FIELD_MIN));
    press(0, 1, 1);
    commit_expect("simul", 5'd10, 6'd20);

    // Timeout after 16 idle cycles in EDIT_HOUR
    enter_edit();
    for (int i = 0; i < 15; i++) tick();
    chk("timeout_not_yet", 32'(field), 32'(FIELD_HOUR));
    tick();
    chk("timeout_field", 32'(field), 32'(FIELD_NONE));
    chk("timeout_no_load", 32'({cif.hour_load, cif.min_load, blink}), 32'd0);
    tick();

    // Reset in the middle of EDIT_MIN
    set_counters(5'd5, 6'd6);
    enter_edit();
    press(1, 0, 0);
    press(0, 1, 0);
    chk("pre_reset_field", 32'(field), 32'(FIELD_MIN));
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_field_blink", 32'({field, blink}), 32'd0);
    chk("reset_mid_strobes", 32'({cif.hour_en, cif.min_en, cif.hour_load, cif.min_load}), 32'd0);
    chk("reset_mid_data", 32'({cif.hour_data, cif.min_data}), 32'd0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'({field, cif.hour_en, cif.min_en}), 32'd0);
    press(1, 0, 0);
    chk("post_reset_capture", 32'({cif.hour_en, cif.min_en}), 32'd3);
    tick();
    press(1, 0, 0);
    commit_expect("post_reset", 5'd5, 6'd6);

    // Out-of-range capture is clamped to 0
    set_counters(5'd27, 6'd62);
    enter_edit();
    press(1, 0, 0);
    commit_expect("clamp", 5'd0, 6'd0);

    tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("load_count", 32'(n_loads), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
